// File: rtl/lock_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lock_pkg
// Description : Shared constants for the keypad lock sequencing controller:
//               FSM state encodings, keypad digit width and clear-key range.
// Revision    : 1.0 - initial release
// ============================================================================
package lock_pkg;

    // Width of one keypad symbol
    localparam int DIGIT_W = 4;

    // Key codes at or above this value are "clear" keys, below are digits
    localparam logic [DIGIT_W-1:0] KEY_CLEAR_MIN = 4'd10;

    // FSM state encodings, exported on Present_State
    localparam logic [3:0] ST_IDLE    = 4'hF;
    localparam logic [3:0] ST_ENTRY   = 4'h1;
    localparam logic [3:0] ST_CHECK   = 4'h2;
    localparam logic [3:0] ST_OPEN    = 4'h3;
    localparam logic [3:0] ST_FAIL    = 4'h4;
    localparam logic [3:0] ST_LOCKOUT = 4'h5;
    localparam logic [3:0] ST_PROG    = 4'h6;

    // True when the key code is a numeric digit rather than a clear key
    function automatic logic is_digit(input logic [DIGIT_W-1:0] key);
        return (key < KEY_CLEAR_MIN);
    endfunction

endpackage : lock_pkg
`default_nettype wire

// File: rtl/lock_cycle_timer.sv
`default_nettype none
// ============================================================================
// Module      : lock_cycle_timer
// Description : Loadable down-counter. Holds at zero; o_expired is high on
//               every cycle the count reads zero. A load overrides counting.
// Revision    : 1.0 - initial release
// ============================================================================
module lock_cycle_timer
    import lock_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    output logic             o_expired
);

    logic [WIDTH-1:0] r_count;

    // Count down towards zero; a load restarts the interval
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_expired = (r_count == '0);

endmodule : lock_cycle_timer
`default_nettype wire

// File: rtl/lock_sequence_controller.sv
`default_nettype none
// ============================================================================
// Module      : lock_sequence_controller
// Description : Keypad lock sequencer. Collects digits, compares against a
//               programmable code, drives Unlock / Error / Alarm, counts
//               failed attempts, enforces lockout and supports reprogramming.
// Revision    : 1.0 - initial release
// ============================================================================
module lock_sequence_controller
    import lock_pkg::*;
#(
    parameter int                          CODE_LEN       = 4,
    parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE   = 16'h1234,
    parameter int                          MAX_TRIES      = 3,
    parameter int                          UNLOCK_CYCLES  = 8,
    parameter int                          FAIL_CYCLES    = 4,
    parameter int                          LOCKOUT_CYCLES = 16,
    parameter int                          ENTRY_TIMEOUT  = 32
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Key_Valid,
    input  logic [DIGIT_W-1:0] Key_Digit,
    input  logic               Prog_Req,
    output logic               Unlock,
    output logic               Error,
    output logic               Alarm,
    output logic               Prog_Active,
    output logic [3:0]         Present_State,
    output logic [2:0]         Digit_Count,
    output logic [1:0]         Tries
);

    localparam int c_code_w     = CODE_LEN * DIGIT_W;
    localparam int c_max_a      = (UNLOCK_CYCLES > FAIL_CYCLES) ? UNLOCK_CYCLES : FAIL_CYCLES;
    localparam int c_max_b      = (LOCKOUT_CYCLES > ENTRY_TIMEOUT) ? LOCKOUT_CYCLES : ENTRY_TIMEOUT;
    localparam int c_max_cycles = (c_max_a > c_max_b) ? c_max_a : c_max_b;
    localparam int c_timer_w    = (c_max_cycles > 1) ? $clog2(c_max_cycles) : 1;

    // Timer values loaded on entry to each timed state (expiry when it reads 0)
    localparam logic [c_timer_w-1:0] c_load_open    = c_timer_w'(UNLOCK_CYCLES - 1);
    localparam logic [c_timer_w-1:0] c_load_fail    = c_timer_w'(FAIL_CYCLES - 1);
    localparam logic [c_timer_w-1:0] c_load_lockout = c_timer_w'(LOCKOUT_CYCLES - 1);
    localparam logic [c_timer_w-1:0] c_load_entry   = c_timer_w'(ENTRY_TIMEOUT - 1);

    localparam logic [3:0] c_code_len   = 4'(CODE_LEN);
    localparam logic [1:0] c_tries_last = 2'(MAX_TRIES - 1);

    logic [3:0]           r_state;
    logic [3:0]           w_next_state;
    logic [c_code_w-1:0]  r_buf;
    logic [c_code_w-1:0]  w_buf_next;
    logic [c_code_w-1:0]  w_buf_shifted;
    logic [c_code_w-1:0]  r_code;
    logic                 w_code_we;
    logic [2:0]           r_count;
    logic [2:0]           w_count_next;
    logic [3:0]           w_count_inc;
    logic                 w_last_digit;
    logic [1:0]           r_tries;
    logic [1:0]           w_tries_next;
    logic                 w_key_digit;
    logic                 w_key_clear;
    logic                 w_key_reload;
    logic                 w_timer_load;
    logic [c_timer_w-1:0] w_timer_value;
    logic                 w_expired;

    // Key classification and the shifted buffer (newest digit in the LSBs).
    // The count increment is 4 bits wide so an 8-digit code is detectable.
    assign w_key_digit   = Key_Valid && is_digit(Key_Digit);
    assign w_key_clear   = Key_Valid && !is_digit(Key_Digit);
    assign w_buf_shifted = (r_buf << DIGIT_W) | c_code_w'(Key_Digit);
    assign w_count_inc   = {1'b0, r_count} + 4'd1;
    assign w_last_digit  = (w_count_inc == c_code_len);

    lock_cycle_timer #(
        .WIDTH        (c_timer_w)
    ) u_timer (
        .Clk          (Clk),
        .Reset        (Reset),
        .i_load       (w_timer_load),
        .i_load_value (w_timer_value),
        .o_expired    (w_expired)
    );

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state, datapath updates and timer reload selection
    always_comb begin
        w_next_state = r_state;
        w_buf_next   = r_buf;
        w_count_next = r_count;
        w_tries_next = r_tries;
        w_code_we    = 1'b0;
        w_key_reload = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_key_digit) begin
                    w_buf_next   = w_buf_shifted;
                    w_count_next = w_count_inc[2:0];
                    w_next_state = w_last_digit ? ST_CHECK : ST_ENTRY;
                end
            end
            ST_ENTRY: begin
                // A key arriving on the expiry cycle wins over the timeout
                if (w_key_digit) begin
                    w_buf_next   = w_buf_shifted;
                    w_count_next = w_count_inc[2:0];
                    w_key_reload = 1'b1;
                    if (w_last_digit) begin
                        w_next_state = ST_CHECK;
                    end
                end else if (w_key_clear || w_expired) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (r_buf == r_code) begin
                    w_tries_next = 2'd0;
                    w_next_state = ST_OPEN;
                end else if (r_tries == c_tries_last) begin
                    w_next_state = ST_LOCKOUT;
                end else begin
                    w_tries_next = r_tries + 2'd1;
                    w_next_state = ST_FAIL;
                end
            end
            ST_OPEN: begin
                // Programming request beats the unlock expiry; start a fresh entry
                if (Prog_Req) begin
                    w_buf_next   = '0;
                    w_count_next = 3'd0;
                    w_next_state = ST_PROG;
                end else if (w_expired) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_PROG: begin
                if (w_key_digit) begin
                    w_buf_next   = w_buf_shifted;
                    w_count_next = w_count_inc[2:0];
                    w_key_reload = 1'b1;
                    if (w_last_digit) begin
                        w_code_we    = 1'b1;
                        w_next_state = ST_IDLE;
                    end
                end else if (w_key_clear || w_expired) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_FAIL: begin
                if (w_expired) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_LOCKOUT: begin
                if (w_expired) begin
                    w_tries_next = 2'd0;
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase

        // Every return to IDLE starts from an empty entry
        if (w_next_state == ST_IDLE) begin
            w_buf_next   = '0;
            w_count_next = 3'd0;
        end

        w_timer_load = (w_next_state != r_state) || w_key_reload;
        case (w_next_state)
            ST_OPEN:           w_timer_value = c_load_open;
            ST_FAIL:           w_timer_value = c_load_fail;
            ST_LOCKOUT:        w_timer_value = c_load_lockout;
            ST_ENTRY, ST_PROG: w_timer_value = c_load_entry;
            default:           w_timer_value = '0;
        endcase
    end

    // Entry buffer, digit count, failure count and code register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_buf   <= '0;
            r_count <= 3'd0;
            r_tries <= 2'd0;
            r_code  <= DEFAULT_CODE;
        end else begin
            r_buf   <= w_buf_next;
            r_count <= w_count_next;
            r_tries <= w_tries_next;
            if (w_code_we) begin
                r_code <= w_buf_shifted;
            end
        end
    end

    // Outputs decode the registered state
    always_comb begin
        Unlock        = (r_state == ST_OPEN);
        Error         = (r_state == ST_FAIL);
        Alarm         = (r_state == ST_LOCKOUT);
        Prog_Active   = (r_state == ST_PROG);
        Present_State = r_state;
        Digit_Count   = r_count;
        Tries         = r_tries;
    end

endmodule : lock_sequence_controller
`default_nettype wire

// File: tb/tb_lock_sequence_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_lock_sequence_controller
// Description : Self-checking bench for lock_sequence_controller. The driver
//               issues code attempts and pushes the expected output pulse
//               (kind, start cycle, length, Tries) into a queue; a monitor
//               measures every Unlock/Error/Alarm/Prog_Active pulse and
//               compares it with the queue head.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lock_sequence_controller;

    localparam int          CODE_LEN       = 4;
    localparam logic [15:0] DEFAULT_CODE   = 16'h1234;
    localparam int          MAX_TRIES      = 3;
    localparam int          UNLOCK_CYCLES  = 8;
    localparam int          FAIL_CYCLES    = 4;
    localparam int          LOCKOUT_CYCLES = 16;
    localparam int          ENTRY_TIMEOUT  = 32;

    localparam int K_UNLOCK = 0;
    localparam int K_ERROR  = 1;
    localparam int K_ALARM  = 2;
    localparam int K_PROG   = 3;

    logic       Clk       = 1'b0;
    logic       Reset     = 1'b1;
    logic       Key_Valid = 1'b0;
    logic [3:0] Key_Digit = 4'd0;
    logic       Prog_Req  = 1'b0;
    logic       Unlock;
    logic       Error;
    logic       Alarm;
    logic       Prog_Active;
    logic [3:0] Present_State;
    logic [2:0] Digit_Count;
    logic [1:0] Tries;

    lock_sequence_controller #(
        .CODE_LEN       (CODE_LEN),
        .DEFAULT_CODE   (DEFAULT_CODE),
        .MAX_TRIES      (MAX_TRIES),
        .UNLOCK_CYCLES  (UNLOCK_CYCLES),
        .FAIL_CYCLES    (FAIL_CYCLES),
        .LOCKOUT_CYCLES (LOCKOUT_CYCLES),
        .ENTRY_TIMEOUT  (ENTRY_TIMEOUT)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .Key_Valid     (Key_Valid),
        .Key_Digit     (Key_Digit),
        .Prog_Req      (Prog_Req),
        .Unlock        (Unlock),
        .Error         (Error),
        .Alarm         (Alarm),
        .Prog_Active   (Prog_Active),
        .Present_State (Present_State),
        .Digit_Count   (Digit_Count),
        .Tries         (Tries)
    );

    always #5 Clk = ~Clk;

    // Cycle index: value during the interval following each posedge
    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int start;
        int len;
        int tries;
    } ev_t;

    ev_t         exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          model_tries = 0;
    logic [15:0] model_code = DEFAULT_CODE;
    int          last_key_cyc = 0;

    function automatic string kind_name(input int k);
        case (k)
            K_UNLOCK: return "unlock";
            K_ERROR:  return "error";
            K_ALARM:  return "alarm";
            default:  return "prog";
        endcase
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic score(input int k, input int st, input int len, input int tr);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL pulse_%s: unexpected pulse start=%0d len=%0d tries=%0d", kind_name(k), st, len, tr);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.start != st || e.len != len || e.tries != tr) begin
                n_errors++;
                $display("FAIL pulse_%s: got %s start=%0d len=%0d tries=%0d expected %s start=%0d len=%0d tries=%0d",
                         kind_name(e.kind), kind_name(k), st, len, tr, kind_name(e.kind), e.start, e.len, e.tries);
            end
        end
    endtask

    // Monitor: measure each output pulse; reset aborts pulses in flight
    logic [3:0] mon_active = 4'b0;
    int         mon_start[4];
    int         mon_tries[4];
    initial begin
        logic [3:0] outs;
        forever begin
            @(negedge Clk);
            outs = {Prog_Active, Alarm, Error, Unlock};
            if (Reset) begin
                mon_active = 4'b0;
            end else begin
                for (int k = 0; k < 4; k++) begin
                    if (outs[k] && !mon_active[k]) begin
                        mon_active[k] = 1'b1;
                        mon_start[k]  = cyc;
                        mon_tries[k]  = int'(Tries);
                    end else if (!outs[k] && mon_active[k]) begin
                        mon_active[k] = 1'b0;
                        score(k, mon_start[k], cyc - mon_start[k], mon_tries[k]);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic press(input logic [3:0] d);
        Key_Valid    = 1'b1;
        Key_Digit    = d;
        last_key_cyc = cyc;
        tick();
        Key_Valid    = 1'b0;
    endtask

    function automatic logic [15:0] rand_code();
        logic [15:0] r;
        for (int i = 0; i < CODE_LEN; i++) r[i*4 +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    // One code attempt; the expected outcome comes from the code/tries rules.
    // prog_k > 0 requests programming in the prog_k-th OPEN cycle and enters
    // prog_digits digits of new_code (fewer than CODE_LEN leaves PROG open).
    task automatic attempt(input logic [15:0] seq, input int prog_k,
                           input logic [15:0] new_code, input int prog_digits);
        int  p, len, s, pk;
        ev_t e;
        pk = prog_k;
        for (int i = 0; i < CODE_LEN; i++) begin
            press(seq[(CODE_LEN-1-i)*4 +: 4]);
            if (i < CODE_LEN - 1) repeat ($urandom_range(0, 3)) tick();
        end
        p = last_key_cyc;
        if (seq == model_code) begin
            model_tries = 0;
            len = (pk > 0) ? pk : UNLOCK_CYCLES;
            e = '{K_UNLOCK, p + 2, len, 0};
        end else if (model_tries + 1 == MAX_TRIES) begin
            e = '{K_ALARM, p + 2, LOCKOUT_CYCLES, model_tries};
            model_tries = 0;
            len = LOCKOUT_CYCLES;
            pk = 0;
        end else begin
            model_tries++;
            e = '{K_ERROR, p + 2, FAIL_CYCLES, model_tries};
            len = FAIL_CYCLES;
            pk = 0;
        end
        exp_q.push_back(e);

        if (pk == 0) begin
            // Keys during CHECK / OPEN / FAIL / LOCKOUT must be ignored
            while (cyc < p + 2 + len) begin
                if ($urandom_range(0, 3) == 0) press(4'($urandom_range(0, 15)));
                else tick();
            end
            check("state_after_attempt", int'(Present_State), 15);
            check("tries_after_attempt", int'(Tries), model_tries);
        end else begin
            while (cyc < p + 2 + pk - 1) tick();
            Prog_Req = 1'b1;
            tick();
            Prog_Req = 1'b0;
            s = cyc;
            for (int i = 0; i < prog_digits; i++) begin
                press(new_code[(CODE_LEN-1-i)*4 +: 4]);
                if (i < prog_digits - 1) repeat ($urandom_range(0, 3)) tick();
            end
            if (prog_digits == CODE_LEN) begin
                exp_q.push_back('{K_PROG, s, cyc - s, 0});
                model_code = new_code;
                check("state_after_prog", int'(Present_State), 15);
            end
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_state"}, int'(Present_State), 15);
        check({tag, "_outs"}, int'({Unlock, Error, Alarm, Prog_Active}), 0);
        check({tag, "_count"}, int'(Digit_Count), 0);
        check({tag, "_tries"}, int'(Tries), 0);
    endtask

    task automatic apply_reset();
        Reset = 1'b1;
        tick();
        check_reset_state("reset");
        Reset = 1'b0;
        model_code  = DEFAULT_CODE;
        model_tries = 0;
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int          p;
        int          pk;
        logic [15:0] seq;
        logic [15:0] wrong;

        // Reset state
        repeat (3) tick();
        check_reset_state("por");
        Reset = 1'b0;
        tick();

        // Correct default code
        attempt(16'h1234, 0, 16'h0, CODE_LEN);

        // Two wrong codes, then lockout on the third
        attempt(16'h1235, 0, 16'h0, CODE_LEN);
        attempt(16'h1235, 0, 16'h0, CODE_LEN);
        check("tries_two_fails", int'(Tries), 2);
        attempt(16'h1235, 0, 16'h0, CODE_LEN);
        check("tries_after_lockout", int'(Tries), 0);

        // Reprogram to 9876 in the third OPEN cycle; old code fails, new opens
        attempt(16'h1234, 3, 16'h9876, CODE_LEN);
        attempt(16'h1234, 0, 16'h0, CODE_LEN);
        attempt(16'h9876, 0, 16'h0, CODE_LEN);

        // Entry timeout abandons the entry without counting an attempt
        attempt(16'h1111, 0, 16'h0, CODE_LEN);
        press(4'd1);
        press(4'd2);
        p = last_key_cyc;
        while (cyc < p + ENTRY_TIMEOUT) tick();
        check("timeout_last_entry_cycle", int'(Present_State), 1);
        check("timeout_last_entry_count", int'(Digit_Count), 2);
        tick();
        check("timeout_idle_state", int'(Present_State), 15);
        check("timeout_idle_count", int'(Digit_Count), 0);
        check("timeout_tries_kept", int'(Tries), model_tries);

        // Key on the exact expiry cycle keeps ENTRY and reloads the timer
        press(4'd1);
        press(4'd2);
        p = last_key_cyc;
        while (cyc < p + ENTRY_TIMEOUT) tick();
        press(4'd5);
        check("expiry_key_state", int'(Present_State), 1);
        check("expiry_key_count", int'(Digit_Count), 3);
        p = last_key_cyc;
        while (cyc < p + ENTRY_TIMEOUT) tick();
        check("reloaded_timer_still_entry", int'(Present_State), 1);
        tick();
        check("reloaded_timer_expired", int'(Present_State), 15);

        // Clear key abandons the entry
        press(4'd1);
        check("clear_pre_count", int'(Digit_Count), 1);
        press(4'd2);
        press(4'hA);
        check("clear_state", int'(Present_State), 15);
        check("clear_count", int'(Digit_Count), 0);
        check("clear_tries", int'(Tries), model_tries);

        // Randomized attempts, with occasional reprogramming and idle noise
        for (int n = 0; n < 30; n++) begin
            repeat ($urandom_range(0, 4)) begin
                if ($urandom_range(0, 3) == 0) begin
                    press(4'($urandom_range(10, 15)));
                end else begin
                    Prog_Req = 1'($urandom_range(0, 1));
                    tick();
                    Prog_Req = 1'b0;
                end
            end
            seq = ($urandom_range(0, 1) == 1) ? model_code : rand_code();
            pk  = 0;
            if (seq == model_code && $urandom_range(0, 2) == 0) pk = $urandom_range(1, UNLOCK_CYCLES);
            attempt(seq, pk, rand_code(), CODE_LEN);
        end

        // Reset during LOCKOUT
        wrong = (model_code == 16'h1111) ? 16'h2222 : 16'h1111;
        while (model_tries != MAX_TRIES - 1) attempt(wrong, 0, 16'h0, CODE_LEN);
        for (int i = 0; i < CODE_LEN; i++) press(wrong[(CODE_LEN-1-i)*4 +: 4]);
        repeat (5) tick();
        check("alarm_before_reset", int'(Alarm), 1);
        apply_reset();
        attempt(16'h1234, 0, 16'h0, CODE_LEN);

        // Reset during PROG after two new digits; code reverts to default
        attempt(16'h1234, 2, 16'h5678, 2);
        check("prog_active_before_reset", int'(Prog_Active), 1);
        check("prog_count_before_reset", int'(Digit_Count), 2);
        apply_reset();
        attempt(16'h1234, 0, 16'h0, CODE_LEN);

        repeat (5) tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_lock_sequence_controller
`default_nettype wire
